// File: rtl/input_loader.sv
// Writer side of the m1 input SRAM: packs a 32-bit word stream into 128-bit lines,
// writes them from BASE_ADDR upward, then writes a length header and kicks the pipeline.
module input_loader #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned LINE_WIDTH = 128,
    parameter int unsigned WORD_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] HDR_ADDR  = '0,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(1)
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic [ADDR_WIDTH-1:0] m1WriteAddr,
    output logic [LINE_WIDTH-1:0] m1WriteVal,
    output logic                  m1WE,
    output logic                  done,
    output logic                  pipe_start,
    output logic                  overflow
);

    localparam int unsigned LANES  = LINE_WIDTH / WORD_WIDTH;
    localparam int unsigned LANE_W = $clog2(LANES);
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    typedef enum logic [1:0] {StIdle, StFill, StHeader, StDone} state_e;

    state_e                  state_q, state_d;
    logic [LANE_W-1:0]       lane_q, lane_d;
    logic [31:0]             count_q, count_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LINE_WIDTH-1:0]   line_q, line_d;
    logic                    ovf_q, ovf_d;
    logic                    done_q, done_d;
    logic                    pipe_q, pipe_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
    logic [LINE_WIDTH-1:0]   wval_q, wval_d;
    logic [LINE_WIDTH-1:0]   merged;
    logic [LINE_WIDTH-1:0]   hdr;
    logic                    beat;

    assign in_ready = (state_q == StFill);
    assign beat     = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        count_d = count_q;
        addr_d  = addr_q;
        line_d  = line_q;
        ovf_d   = ovf_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wval_d  = wval_q;

        // First word of a line lands in the MSBs; lanes not yet filled stay zero.
        merged = line_q;
        for (int k = 0; k < LANES; k++) begin
            if (lane_q == k[LANE_W-1:0]) begin
                merged[LINE_WIDTH-1-WORD_WIDTH*k -: WORD_WIDTH] = in_data;
            end
        end

        hdr               = '0;
        hdr[LINE_WIDTH-1] = ovf_q;
        hdr[31:0]         = count_q;

        unique case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StFill;
                    lane_d  = '0;
                    count_d = '0;
                    addr_d  = BASE_ADDR;
                    line_d  = '0;
                end
            end
            StFill: begin
                if (beat) begin
                    count_d = count_q + 32'd1;
                    line_d  = merged;
                    lane_d  = lane_q + 1'b1;
                    if (lane_q == LAST_LANE || in_last) begin
                        we_d    = 1'b1;
                        waddr_d = addr_q;
                        wval_d  = merged;
                        line_d  = '0;
                        lane_d  = '0;
                        addr_d  = addr_q + 1'b1;
                        if (in_last) begin
                            state_d = StHeader;
                        end else if (addr_q == '1) begin
                            // m1 is full: truncate the message here.
                            state_d = StHeader;
                            ovf_d   = 1'b1;
                        end
                    end
                end
            end
            StHeader: begin
                we_d    = 1'b1;
                waddr_d = HDR_ADDR;
                wval_d  = hdr;
                state_d = StDone;
            end
            StDone: begin
                if (!enable) begin
                    state_d = StIdle;
                    ovf_d   = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        // done lags entry into DONE by one cycle; pipe_start fires alongside the first done.
        done_d = (state_q == StDone) && (state_d == StDone);
        pipe_d = (state_q == StDone) && !done_q && !pipe_q;
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q <= StIdle;
            lane_q  <= '0;
            count_q <= '0;
            addr_q  <= BASE_ADDR;
            line_q  <= '0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            pipe_q  <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wval_q  <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            line_q  <= line_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            pipe_q  <= pipe_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wval_q  <= wval_d;
        end
    end

    assign m1WE        = we_q;
    assign m1WriteAddr = waddr_q;
    assign m1WriteVal  = wval_q;
    assign done        = done_q;
    assign pipe_start  = pipe_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_input_loader.sv
// Scoreboard bench for input_loader; the address space is shrunk to 8 bits so the
// end-of-m1 truncation case runs in about a thousand beats.
module tb_input_loader;

    localparam int unsigned AW = 8;
    localparam int unsigned LW = 128;
    localparam int unsigned WW = 32;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [LW-1:0] d;
    } wr_t;

    logic          clock = 1'b0;
    logic          rst, enable, in_valid, in_ready, in_last;
    logic [WW-1:0] in_data;
    logic [AW-1:0] m1WriteAddr;
    logic [LW-1:0] m1WriteVal;
    logic          m1WE, done, pipe_start, overflow;

    input_loader #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .WORD_WIDTH(WW)) dut (
        .clock       (clock),
        .rst         (rst),
        .enable      (enable),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .m1WriteAddr (m1WriteAddr),
        .m1WriteVal  (m1WriteVal),
        .m1WE        (m1WE),
        .done        (done),
        .pipe_start  (pipe_start),
        .overflow    (overflow)
    );

    always #5 clock = ~clock;

    int  cyc = 0;
    int  n_chk = 0;
    int  n_pass = 0;
    int  we_count = 0;
    bit  track_ready = 1'b0;
    bit  ready_drop = 1'b0;
    wr_t exp_q[$];

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    // Monitor: every m1 write is popped against the expected-write queue.
    always @(negedge clock) begin
        if (m1WE === 1'b1) begin
            wr_t e;
            we_count++;
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_write: got addr %h data %h, want no write",
                         m1WriteAddr, m1WriteVal);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", LW'(m1WriteAddr), LW'(e.a));
                chk("wr_data", m1WriteVal, e.d);
            end
        end
    end

    task automatic push(input logic [AW-1:0] a, input logic [LW-1:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic send(input logic [WW-1:0] d, input logic l, input int gap, output int n_acc);
        bit rdy;
        int t;
        in_valid = 1'b0;
        repeat (gap) begin
            @(negedge clock);
            if (track_ready && in_ready !== 1'b1) ready_drop = 1'b1;
            @(posedge clock);
            #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        t = 0;
        do begin
            @(negedge clock);
            rdy = (in_ready === 1'b1);
            if (track_ready && !rdy) ready_drop = 1'b1;
            @(posedge clock);
            #1;
            t++;
        end while (!rdy && t < 50);
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!rdy) begin
            n_chk++;
            $display("FAIL accept_timeout: got no in_ready, want beat accepted");
        end
        n_acc = cyc - 1;
    endtask

    task automatic wait_done(input int n_last, input string name);
        int t = 0;
        do begin
            @(negedge clock);
            t++;
        end while (done !== 1'b1 && t < 20);
        chk({name, "_done_latency"}, LW'(cyc - n_last), LW'(3));
        chk({name, "_pipe_start"}, LW'(pipe_start), LW'(1));
    endtask

    task automatic drop_enable(input string name);
        @(posedge clock);
        #1 enable = 1'b0;
        repeat (2) @(negedge clock);
        chk({name, "_done_clear"}, LW'(done), LW'(0));
        chk({name, "_idle_ready"}, LW'(in_ready), LW'(0));
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_we"}, LW'(m1WE), LW'(0));
        chk({name, "_addr"}, LW'(m1WriteAddr), LW'(0));
        chk({name, "_val"}, m1WriteVal, LW'(0));
        chk({name, "_done"}, LW'(done), LW'(0));
        chk({name, "_pipe"}, LW'(pipe_start), LW'(0));
        chk({name, "_ovf"}, LW'(overflow), LW'(0));
        chk({name, "_ready"}, LW'(in_ready), LW'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no end of test, want $finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int            n_last;
        int            lows;
        int            pcnt;
        int            we_base;
        int            lane;
        logic [LW-1:0] line;
        logic [AW-1:0] addr;

        rst = 1'b1; enable = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk_reset("reset");
        @(posedge clock);
        #1 rst = 1'b0;

        // 8 words, two full lines, then hold enable in DONE.
        enable = 1'b1;
        push(8'd1, 128'h00000011_00000022_00000033_00000044);
        push(8'd2, 128'h00000055_00000066_00000077_00000088);
        push(8'd0, 128'h8);
        for (int i = 0; i < 8; i++) send(32'h11 * (i + 1), i == 7, 0, n_last);
        wait_done(n_last, "t1");
        lows = 0;
        pcnt = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (done !== 1'b1) lows++;
            if (pipe_start === 1'b1) pcnt++;
        end
        chk("t6_done_held", LW'(lows), LW'(0));
        chk("t6_pipe_single", LW'(pcnt), LW'(1));
        drop_enable("t6");

        // 5 words: second line only partly filled.
        we_base = we_count;
        enable = 1'b1;
        push(8'd1, 128'h00000011_00000022_00000033_00000044);
        push(8'd2, 128'h00000055_00000000_00000000_00000000);
        push(8'd0, 128'h5);
        for (int i = 0; i < 5; i++) send(32'h11 * (i + 1), i == 4, 0, n_last);
        wait_done(n_last, "t2");
        drop_enable("t2");
        chk("t2_we_pulses", LW'(we_count - we_base), LW'(3));

        // Test 1 again with random idle gaps between beats.
        enable = 1'b1;
        push(8'd1, 128'h00000011_00000022_00000033_00000044);
        push(8'd2, 128'h00000055_00000066_00000077_00000088);
        push(8'd0, 128'h8);
        ready_drop = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send(32'h11 * (i + 1), i == 7, (i == 0) ? 0 : int'($urandom_range(0, 3)), n_last);
            track_ready = (i < 7);
        end
        chk("t3_ready_in_fill", LW'(ready_drop), LW'(0));
        wait_done(n_last, "t3");
        drop_enable("t3");

        // Reset after 6 beats: only the first line reaches m1.
        enable = 1'b1;
        push(8'd1, 128'h000000a1_000000a2_000000a3_000000a4);
        for (int i = 0; i < 6; i++) send(32'ha1 + i, 1'b0, 0, n_last);
        rst = 1'b1;
        enable = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk_reset("t4_rst");
        @(posedge clock);
        #1 rst = 1'b0;
        enable = 1'b1;
        push(8'd1, 128'h000000b1_000000b2_000000b3_000000b4);
        push(8'd0, 128'h4);
        for (int i = 0; i < 4; i++) send(32'hb1 + i, i == 3, 0, n_last);
        wait_done(n_last, "t4");
        drop_enable("t4");

        // Fill m1 to its last address without in_last: truncation and overflow.
        enable = 1'b1;
        addr = 8'd1;
        lane = 0;
        line = '0;
        for (int i = 0; i < 1020; i++) begin
            line[LW-1-WW*lane -: WW] = 32'(i + 1);
            if (lane == 3) begin
                push(addr, line);
                addr = addr + 1'b1;
                line = '0;
                lane = 0;
            end else begin
                lane++;
            end
        end
        push(8'd0, {1'b1, 95'b0, 32'd1020});
        for (int i = 0; i < 1020; i++) send(32'(i + 1), 1'b0, 0, n_last);
        in_valid = 1'b1;
        in_data  = 32'hdead_beef;
        @(negedge clock);
        chk("t5_ready_after_trunc", LW'(in_ready), LW'(0));
        wait_done(n_last, "t5");
        chk("t5_overflow", LW'(overflow), LW'(1));
        chk("t5_ready_in_done", LW'(in_ready), LW'(0));
        in_valid = 1'b0;
        drop_enable("t5");
        chk("t5_overflow_clear", LW'(overflow), LW'(0));

        repeat (3) @(negedge clock);
        chk("queue_empty", LW'(exp_q.size()), LW'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
